// File: rtl/bus_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : bus_serial_tx
// Brief   : Bus-strobed byte to asynchronous serial frame (LSB first, idle
//           high). Holding reg + PISO shift reg + bit divider + bit counter.
//           Define TX_PARITY_EN to insert an even-parity bit before stop.
// Rev     : 1.0  initial release
// ============================================================================
module bus_serial_tx #(
  parameter int DIV = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] D,
  input  logic       LOADB,
  output logic       FULL,
  output logic       BUSY,
  output logic       TXD
);

  localparam logic [7:0] c_DIV_M1 = 8'(DIV - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t     r_state, w_state_nxt;
  logic [7:0] r_div, w_div_nxt;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_full, w_full_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_txd, w_txd_nxt;
  logic       w_load;
`ifdef TX_PARITY_EN
  logic       r_par, w_par_nxt;
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state  <= S_IDLE;
      r_div    <= 8'd0;
      r_bitcnt <= 3'd0;
      r_hold   <= 8'd0;
      r_shift  <= 8'd0;
      r_full   <= 1'b0;
      r_busy   <= 1'b0;
      r_txd    <= 1'b1;
`ifdef TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_hold   <= w_hold_nxt;
      r_shift  <= w_shift_nxt;
      r_full   <= w_full_nxt;
      r_busy   <= w_busy_nxt;
      r_txd    <= w_txd_nxt;
`ifdef TX_PARITY_EN
      r_par    <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bitcnt_nxt = r_bitcnt;
    w_hold_nxt   = r_hold;
    w_shift_nxt  = r_shift;
    w_full_nxt   = r_full;
    w_txd_nxt    = r_txd;
    w_load       = 1'b0;
`ifdef TX_PARITY_EN
    w_par_nxt    = r_par;
`endif

    // A write is only accepted into an empty holding register, so it can
    // never coincide with a holding-to-shift transfer.
    if (!LOADB && !r_full) begin
      w_hold_nxt = D;
      w_full_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (r_full) w_load = 1'b1;
      end
      S_START: begin
        if (r_div == 8'd0) begin
          w_state_nxt  = S_DATA;
          w_div_nxt    = c_DIV_M1;
          w_txd_nxt    = r_shift[0];
          w_bitcnt_nxt = 3'd0;
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end
      S_DATA: begin
        if (r_div == 8'd0) begin
          w_div_nxt = c_DIV_M1;
          if (r_bitcnt == 3'd7) begin
            w_bitcnt_nxt = 3'd0;
`ifdef TX_PARITY_EN
            w_state_nxt  = S_PARITY;
            w_txd_nxt    = r_par;
`else
            w_state_nxt  = S_STOP;
            w_txd_nxt    = 1'b1;
`endif
          end else begin
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_txd_nxt    = r_shift[1];
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (r_div == 8'd0) begin
          w_state_nxt = S_STOP;
          w_div_nxt   = c_DIV_M1;
          w_txd_nxt   = 1'b1;
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end
`endif
      S_STOP: begin
        if (r_div == 8'd0) begin
          if (r_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = 8'd0;
        w_txd_nxt   = 1'b1;
      end
    endcase

    // Shared by IDLE and end-of-STOP so back-to-back frames have no gap.
    if (w_load) begin
      w_state_nxt = S_START;
      w_txd_nxt   = 1'b0;
      w_div_nxt   = c_DIV_M1;
      w_shift_nxt = r_hold;
      w_full_nxt  = 1'b0;
`ifdef TX_PARITY_EN
      w_par_nxt   = ^r_hold;
`endif
    end
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  assign FULL = r_full;
  assign BUSY = r_busy;
  assign TXD  = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_bus_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_serial_tx
// Brief   : Scoreboard bench: stimulus queues expected frames, a line monitor
//           decodes TXD and compares bit by bit.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bus_serial_tx;

  localparam int DIV = 4;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] D = 8'h00;
  logic       LOADB = 1'b1;
  logic       FULL, BUSY, TXD;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         exp_start;
  } exp_t;

  exp_t q[$];
  int   starts[$];

  bus_serial_tx #(.DIV(DIV)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .D     (D),
    .LOADB (LOADB),
    .FULL  (FULL),
    .BUSY  (BUSY),
    .TXD   (TXD)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strobe one byte; k returns the cycle number of the write edge.
  task automatic write1(input logic [7:0] v, output int k);
    @(negedge CLK);
    D     = v;
    LOADB = 1'b0;
    @(negedge CLK);
    LOADB = 1'b1;
    k     = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((BUSY !== 1'b0 || FULL !== 1'b0) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout busy=%b full=%b required 0 0", BUSY, FULL);
    end
    repeat (2) @(negedge CLK);
  endtask

  // Line monitor: a low TXD while idle opens a frame checked against the queue.
  initial begin : monitor
    exp_t           e;
    logic [NB-1:0]  bits;
    logic           ok;
    logic           bad_txd;
    forever begin
      @(negedge CLK);
      if (CLR || TXD !== 1'b0) continue;
      starts.push_back(cyc);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, none expected", cyc);
        repeat (NB*DIV - 1) @(negedge CLK);
        continue;
      end
      e = q.pop_front();
      if (e.exp_start >= 0) chk("start_cycle", cyc, e.exp_start);
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
`ifdef TX_PARITY_EN
      bits[9] = ^e.data;
`endif
      bits[NB-1] = 1'b1;
      ok = 1'b1;
      bad_txd = 1'b0;
      for (int c = 0; c < NB*DIV; c++) begin
        if (c > 0) @(negedge CLK);
        if (CLR) break;
        if (TXD !== bits[c/DIV] || BUSY !== 1'b1) begin
          ok = 1'b0;
          bad_txd = TXD;
        end
        if (c % DIV == DIV-1) begin
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL frame_bit: byte %02h bit %0d got txd=%b busy=%b required txd=%b busy=1",
                     e.data, c/DIV, bad_txd, BUSY, bits[c/DIV]);
          end
          ok = 1'b1;
        end
      end
    end
  end

  initial begin : stim
    int  k, k1, k2, k3;
    bit  bad;

    @(negedge CLK);
    chk("reset_txd", int'(TXD), 1);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_full", int'(FULL), 0);
    repeat (2) @(negedge CLK);
    CLR = 1'b0;

    bad = 1'b0;
    repeat (50) begin
      @(negedge CLK);
      if (TXD !== 1'b1 || BUSY !== 1'b0 || FULL !== 1'b0) bad = 1'b1;
    end
    chk("idle_50_cycles_bad", int'(bad), 0);

    // Single byte 0xA5: latency, FULL pulse, BUSY span of 10*DIV.
    write1(8'hA5, k);
    q.push_back('{8'hA5, k+1});
    chk("a5_full_after_write", int'(FULL), 1);
    @(negedge CLK);
    chk("a5_full_cleared", int'(FULL), 0);
    chk("a5_busy_start", int'(BUSY), 1);
    chk("a5_txd_start", int'(TXD), 0);
    repeat (NB*DIV - 1) @(negedge CLK);
    chk("a5_busy_last_stop", int'(BUSY), 1);
    @(negedge CLK);
    chk("a5_busy_fall", int'(BUSY), 0);
    chk("a5_txd_idle", int'(TXD), 1);
    wait_idle();

    // Back-to-back: second byte written while first is in DATA.
    write1(8'h01, k1);
    q.push_back('{8'h01, k1+1});
    repeat (15) @(negedge CLK);
    write1(8'hFF, k);
    q.push_back('{8'hFF, k1+1+NB*DIV});
    wait_idle();
    chk("b2b_spacing", starts[starts.size()-1] - starts[starts.size()-2], NB*DIV);

    // Overflow: 0x11 transfers, 0x22 held, 0x33 dropped.
    write1(8'h11, k1);
    q.push_back('{8'h11, k1+1});
    write1(8'h22, k2);
    q.push_back('{8'h22, k1+1+NB*DIV});
    chk("ovf_full_22", int'(FULL), 1);
    write1(8'h33, k3);
    chk("ovf_full_33", int'(FULL), 1);
    wait_idle();

    // Asynchronous reset during data bit 3 of 0x00.
    write1(8'h00, k);
    q.push_back('{8'h00, k+1});
    while (cyc < k + 1 + 4*DIV + 1) @(negedge CLK);
    #2 CLR = 1'b1;
    #1;
    chk("clr_txd", int'(TXD), 1);
    chk("clr_busy", int'(BUSY), 0);
    chk("clr_full", int'(FULL), 0);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    write1(8'h55, k);
    q.push_back('{8'h55, k+1});
    wait_idle();

    write1(8'h07, k);
    q.push_back('{8'h07, k+1});
    wait_idle();
    write1(8'h3C, k);
    q.push_back('{8'h3C, k+1});
    wait_idle();

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
